afifo_rd_drainer: RTL and testbench
===================================

# afifo_rd_drainer

Read-side consumer for the asynchronous FIFO, living entirely in the `rd_clk` domain. It drives `rd_inc` against `rd_empty` and captures `rd_data` into a 2-entry output buffer. Captured words are re-presented as a valid/ready stream. Transfers are command driven: drain exactly `len` words, or stream continuously when `len` is 0, with abort and completion reporting.

## Interface
- `DSIZE`, 8, data width; must match the FIFO's `DSIZE`.
- `CSIZE`, 8, width of the length and word counters.
- `rd_clk` in 1: read-domain clock, the only clock.
- `rd_rst` in 1: reset, asynchronous and active-high.
- `rd_data` in DSIZE: FIFO head word, valid combinationally while `rd_empty` = 0.
- `rd_empty` in 1: FIFO empty flag.
- `rd_inc` out 1: FIFO pop strobe; one word is consumed per rising edge where it is high.
- `start` in 1: single-cycle command pulse; sampled only in IDLE.
- `len` in CSIZE: word count, sampled with `start`; 0 means continuous.
- `abort` in 1: stop popping and finish after the buffer drains.
- `m_data` out DSIZE: output word.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream accept.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse at transfer end.
- `words_out` out CSIZE: handshakes completed in the current or last transfer.

## Operation
- States: IDLE, RUN, DONE (type `drain_state_e`).
- IDLE:
  - `start` = 1 latches `len` into `len_q`, clears `issued` and `words_out`, and moves to RUN.
  - `abort` is ignored in IDLE.
- RUN pop rule: `rd_inc` = RUN & !`rd_empty` & (`buf_cnt` < 2) & !`abort_q` & (`len_q` == 0 | `issued` != `len_q`).
  - `rd_inc` is combinational and must never assert while `rd_empty` = 1.
- Each pop writes `rd_data` into the buffer tail and increments `issued`.
  - `issued` wraps modulo 2^CSIZE in continuous mode.
- Buffer:
  - 2 entries, `buf_cnt` ranges 0..2.
  - `m_valid` = (`buf_cnt` != 0); `m_data` = head entry.
  - Push and pop in the same cycle leave `buf_cnt` unchanged.
- Handshake: once `m_valid` = 1, `m_valid` and `m_data` hold stable until `m_ready` = 1. Data is never dropped or duplicated.
- `words_out` increments on each `m_valid` & `m_ready` and wraps modulo 2^CSIZE.
- `abort` in RUN:
  - Sets `abort_q`, which blocks `rd_inc` from the next cycle.
  - A pop in the same cycle as `abort` still completes.
  - Already-buffered words are still delivered.
- RUN → DONE when `buf_cnt` == 0 and no push is in flight, and either:
  - `len_q` != 0 and `issued` == `len_q`, or
  - `abort_q` = 1.
- Continuous mode ends only via abort.
- DONE: `done` = 1 for exactly one cycle, `abort_q` clears, then IDLE.
- `start` while `busy` = 1 is ignored.
- Reset mid-transfer:
  - State goes to IDLE, all counters clear, and buffered words are discarded.
  - FIFO pointers are reset by the same `rd_rst`.
- Reset values: `rd_inc` 0, `m_valid` 0, `m_data` 0, `busy` 0, `done` 0, `words_out` 0.

## Timing
- `start` sampled at edge 0: RUN from edge 0, so `rd_inc` can assert in cycle 1.
- Pop to output latency is 1 cycle: a pop at edge N gives `m_valid` = 1 after edge N.
- Throughput is 1 word/cycle sustained while `rd_empty` = 0 and `m_ready` = 1.
- Downstream stall: at most 2 further pops, then `rd_inc` deasserts until space frees.
- Last handshake at edge N (finite `len`): DONE after edge N, `done` high in cycle N+1, IDLE after edge N+1.
  - The earliest next `start` is accepted at edge N+2.
- `rd_empty` rising mid-transfer: `rd_inc` drops in the same cycle (combinational gating). The transfer waits in RUN indefinitely.

## Structure
- Add `typedef enum logic [1:0] {IDLE, RUN, DONE} drain_state_e;` to `AFIFO_Pkg`.
- Add a shared constant `DRAIN_BUF_DEPTH = 2` to `AFIFO_Pkg`.
- Sub-module `afifo_skid_buf`: 2-entry register buffer with push/data_in and valid/ready output, parameterized by DSIZE.
- Top `afifo_rd_drainer` holds the FSM, the `issued`/`len_q`/`words_out` counters and the `rd_inc` logic.
- The bench instantiates it beside `FIFO` in the TB top, sharing `vif.rd_clk`, `vif.rd_rst`, `vif.rd_data`, `vif.rd_empty` and `vif.rd_inc`.

## Test plan
- **Basic burst:** write 0x11,0x22,0x33,0x44; `start` with `len` = 4; `m_ready` = 1.
  - Output order is 0x11..0x44, `words_out` = 4, `done` pulses once, the FIFO ends empty, and no `rd_inc` occurs while `rd_empty` = 1.
- **Backpressure:** 8 words (FIFO full), `len` = 8, `m_ready` low for 10 cycles.
  - Exactly 2 pops occur, then `m_data` = word0 holds stable.
  - On release, all 8 words arrive in order and `done` pulses.
- **Underflow stall:** `len` = 6 with only 3 words written, the remaining 3 written 20 cycles later.
  - `busy` stays 1, `rd_inc` stays 0 during the gap, then 6 words arrive and `done` pulses.
- **Continuous + abort:** `len` = 0 with a steady writer; assert `abort` after 5 handshakes while 2 words are buffered.
  - Both buffered words are delivered, no pops occur after the abort cycle, `done` pulses, and `words_out` = 7.
- **Reset mid-transfer:** assert `rd_rst` with `buf_cnt` = 2.
  - Immediately, without waiting for a clock edge: `m_valid` = 0, `busy` = 0, `rd_inc` = 0, `words_out` = 0.
  - A subsequent `len` = 1 transfer after refill completes normally.
- **Command spacing:** a `start` issued while busy is ignored; a `start` in the cycle after `done` is accepted. Check that `words_out` restarts from 0.

Source files
------------

// File: rtl/AFIFO_Pkg.sv
// Shared types and constants for the asynchronous FIFO and its read-side drainer.
package AFIFO_Pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} drain_state_e;

    localparam int unsigned DRAIN_BUF_DEPTH = 2;

endpackage

// File: rtl/afifo_skid_buf.sv
// Two-entry register buffer: words pushed at the tail are re-presented from the head as a
// valid/ready stream; head and data stay stable while the consumer stalls.
module afifo_skid_buf
    import AFIFO_Pkg::*;
#(
    parameter int unsigned DSIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DSIZE-1:0] data_in,
    output logic             valid,
    output logic [DSIZE-1:0] data,
    input  logic             ready,
    output logic [1:0]       cnt
);

    localparam logic [1:0] FULL = 2'(DRAIN_BUF_DEPTH);

    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             pop;

    assign valid = (cnt_q != 2'd0);
    assign data  = head_q;
    assign cnt   = cnt_q;
    assign pop   = valid & ready;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = data_in;
                else               tail_d = data_in;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push and pop: occupancy unchanged, queue shifts by one.
                if (cnt_q == FULL) begin
                    head_d = tail_q;
                    tail_d = data_in;
                end else begin
                    head_d = data_in;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/afifo_rd_drainer.sv
// Read-domain consumer of the async FIFO: pops words into a 2-entry buffer and streams them
// out, draining a fixed count or running continuously until aborted.
module afifo_rd_drainer
    import AFIFO_Pkg::*;
#(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned CSIZE = 8
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic [DSIZE-1:0] rd_data,
    input  logic             rd_empty,
    output logic             rd_inc,
    input  logic             start,
    input  logic [CSIZE-1:0] len,
    input  logic             abort,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic [CSIZE-1:0] words_out
);

    localparam logic [1:0] FULL = 2'(DRAIN_BUF_DEPTH);

    drain_state_e     state_q, state_d;
    logic [CSIZE-1:0] len_q, issued_q, words_q;
    logic             abort_q;
    logic [1:0]       buf_cnt;
    logic             hs, len_left, drained, finished;

    afifo_skid_buf #(
        .DSIZE(DSIZE)
    ) u_buf (
        .clk    (rd_clk),
        .rst    (rd_rst),
        .push   (rd_inc),
        .data_in(rd_data),
        .valid  (m_valid),
        .data   (m_data),
        .ready  (m_ready),
        .cnt    (buf_cnt)
    );

    assign hs        = m_valid & m_ready;
    assign len_left  = (len_q == '0) | (issued_q != len_q);
    assign rd_inc    = (state_q == RUN) & ~rd_empty & (buf_cnt < FULL) & ~abort_q & len_left;
    // Looks one edge ahead so DONE follows the last handshake directly.
    assign drained   = ~rd_inc & ((buf_cnt == 2'd0) | ((buf_cnt == 2'd1) & hs));
    assign finished  = ((len_q != '0) & (issued_q == len_q)) | abort_q;
    assign words_out = words_q;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (drained && finished) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            len_q    <= '0;
            issued_q <= '0;
            words_q  <= '0;
            abort_q  <= 1'b0;
        end else begin
            if ((state_q == IDLE) && start) begin
                len_q    <= len;
                issued_q <= '0;
                words_q  <= '0;
            end else begin
                if (rd_inc) issued_q <= issued_q + CSIZE'(1);
                if (hs)     words_q  <= words_q + CSIZE'(1);
            end
            if ((state_q == RUN) && abort) abort_q <= 1'b1;
            else if (state_q == DONE)      abort_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_afifo_rd_drainer.sv
// Bench for afifo_rd_drainer: a small FIFO model feeds the drainer and a scoreboard queue
// holds every word written, compared in order against each output handshake.
module tb_afifo_rd_drainer;

    logic       rd_clk = 1'b0;
    logic       rd_rst = 1'b0;
    logic [7:0] rd_data;
    logic       rd_empty, rd_inc;
    logic       start, abort, m_valid, m_ready, busy, done;
    logic [7:0] len, m_data, words_out;

    // FIFO model
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] mem [8];
    logic [2:0] wptr, rptr;
    logic [3:0] fcnt;
    int         pops = 0;

    logic [7:0] exp_q[$];
    logic [7:0] wq[$];
    logic       bg_en;
    logic [7:0] bg_val;

    int         n_cmp = 0, n_err = 0, viol = 0, stab_err = 0, done_cnt = 0, hs_cnt = 0;
    logic       hold_v;
    logic [7:0] hold_d;
    int         d0, p0, h0;

    always #5 rd_clk = ~rd_clk;

    afifo_rd_drainer #(
        .DSIZE(8),
        .CSIZE(8)
    ) dut (
        .rd_clk   (rd_clk),
        .rd_rst   (rd_rst),
        .rd_data  (rd_data),
        .rd_empty (rd_empty),
        .rd_inc   (rd_inc),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy),
        .done     (done),
        .words_out(words_out)
    );

    assign rd_empty = (fcnt == 4'd0);
    assign rd_data  = mem[rptr];

    always @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            wptr <= 3'd0;
            rptr <= 3'd0;
            fcnt <= 4'd0;
        end else begin
            if (wr_en) begin
                mem[wptr] <= wr_data;
                wptr      <= wptr + 3'd1;
            end
            if (rd_inc) begin
                rptr <= rptr + 3'd1;
                pops <= pops + 1;
            end
            fcnt <= fcnt + 4'(wr_en) - 4'(rd_inc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Evaluates the cycle's pre-edge values and decides the next FIFO write.
    task automatic sample();
        logic [7:0] e;
        if (rd_rst) begin
            hold_v = 1'b0;
            wr_en  = 1'b0;
            return;
        end
        if (rd_inc && rd_empty) viol++;
        if (hold_v && (!m_valid || m_data != hold_d)) stab_err++;
        hold_v = m_valid && !m_ready;
        hold_d = m_data;
        if (m_valid && m_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                check("data_extra", 32'(m_data), 32'h100);
            end else begin
                e = exp_q.pop_front();
                check("data", 32'(m_data), 32'(e));
            end
        end
        if (done) done_cnt++;
        if (fcnt < 4'd8 && (wq.size() != 0 || bg_en)) begin
            wr_en = 1'b1;
            if (wq.size() != 0) begin
                wr_data = wq.pop_front();
            end else begin
                wr_data = bg_val;
                bg_val  = bg_val + 8'd1;
            end
            exp_q.push_back(wr_data);
        end else begin
            wr_en = 1'b0;
        end
    endtask

    task automatic tick();
        #1;
        sample();
        @(negedge rd_clk);
    endtask

    task automatic wait_done(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_words(input logic [7:0] target, input string tag);
        for (int i = 0; i < 200; i++) begin
            if (words_out == target) break;
            tick();
        end
        check(tag, 32'(words_out), 32'(target));
    endtask

    initial begin
        start = 1'b0; len = 8'd0; abort = 1'b0; m_ready = 1'b0;
        wr_en = 1'b0; wr_data = 8'd0; bg_en = 1'b0; bg_val = 8'hC0; hold_v = 1'b0;
        hold_d = 8'd0;
        #1 rd_rst = 1'b1;
        #1;
        check("rst_rd_inc", 32'(rd_inc), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_words_out", 32'(words_out), 32'd0);
        @(negedge rd_clk);
        @(negedge rd_clk);
        rd_rst = 1'b0;

        // Basic burst
        m_ready = 1'b1;
        wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33); wq.push_back(8'h44);
        repeat (6) tick();
        d0 = done_cnt;
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        wait_done("basic_done");
        repeat (3) tick();
        check("basic_words", 32'(words_out), 32'd4);
        check("basic_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("basic_sb_empty", 32'(exp_q.size()), 32'd0);
        check("basic_fifo_empty", 32'(rd_empty), 32'd1);

        // Backpressure with a full FIFO
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) wq.push_back(8'hA0 + 8'(i));
        repeat (10) tick();
        check("bp_fifo_full", 32'(fcnt), 32'd8);
        p0 = pops; d0 = done_cnt;
        start = 1'b1; len = 8'd8;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("bp_pops", 32'(pops - p0), 32'd2);
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_head", 32'(m_data), 32'hA0);
        m_ready = 1'b1;
        wait_done("bp_done");
        repeat (3) tick();
        check("bp_words", 32'(words_out), 32'd8);
        check("bp_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Underflow stall
        wq.push_back(8'hB0); wq.push_back(8'hB1); wq.push_back(8'hB2);
        repeat (5) tick();
        start = 1'b1; len = 8'd6;
        tick();
        start = 1'b0;
        wait_words(8'd3, "uf_first3");
        p0 = pops; d0 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!busy) d0++;
        end
        check("uf_busy_gap", 32'(d0), 32'd0);
        check("uf_pops_gap", 32'(pops - p0), 32'd0);
        check("uf_rd_inc", 32'(rd_inc), 32'd0);
        wq.push_back(8'hB3); wq.push_back(8'hB4); wq.push_back(8'hB5);
        wait_done("uf_done");
        repeat (2) tick();
        check("uf_words", 32'(words_out), 32'd6);
        check("uf_sb_empty", 32'(exp_q.size()), 32'd0);

        // Continuous mode ended by abort with two words buffered
        bg_en = 1'b1;
        repeat (10) tick();
        p0 = pops; h0 = hs_cnt; d0 = done_cnt;
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        wait_words(8'd5, "ab_five");
        m_ready = 1'b0;
        tick();
        check("ab_buffered", 32'((pops - p0) - (hs_cnt - h0)), 32'd2);
        abort = 1'b1;
        p0 = pops;
        tick();
        abort = 1'b0;
        m_ready = 1'b1;
        wait_done("ab_done");
        repeat (2) tick();
        check("ab_no_pops", 32'(pops - p0), 32'd0);
        check("ab_words", 32'(words_out), 32'd7);
        check("ab_done_cnt", 32'(done_cnt - d0), 32'd1);
        bg_en = 1'b0;

        // Reset in the middle of a transfer
        m_ready = 1'b0;
        repeat (2) tick();
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("mr_pre_valid", 32'(m_valid), 32'd1);
        rd_rst = 1'b1;
        #1;
        check("mr_m_valid", 32'(m_valid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_rd_inc", 32'(rd_inc), 32'd0);
        check("mr_words_out", 32'(words_out), 32'd0);
        exp_q.delete();
        wq.delete();
        wr_en = 1'b0;
        hold_v = 1'b0;
        tick();
        tick();
        rd_rst = 1'b0;
        wq.push_back(8'hD5);
        m_ready = 1'b1;
        repeat (4) tick();
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        wait_done("mr_done");
        repeat (2) tick();
        check("mr_words", 32'(words_out), 32'd1);
        check("mr_sb_empty", 32'(exp_q.size()), 32'd0);

        // Command spacing
        m_ready = 1'b0;
        wq.push_back(8'hE0); wq.push_back(8'hE1); wq.push_back(8'hF1);
        repeat (5) tick();
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("cmd_busy", 32'(busy), 32'd1);
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        m_ready = 1'b1;
        wait_done("cmd_done1");
        check("cmd_words1", 32'(words_out), 32'd2);
        tick();
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        check("cmd_accept", 32'(busy), 32'd1);
        check("cmd_restart", 32'(words_out), 32'd0);
        wait_done("cmd_done2");
        repeat (2) tick();
        check("cmd_words2", 32'(words_out), 32'd1);
        check("cmd_sb_empty", 32'(exp_q.size()), 32'd0);
        check("cmd_fifo_empty", 32'(rd_empty), 32'd1);

        check("inc_while_empty", 32'(viol), 32'd0);
        check("stall_stability", 32'(stab_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
